// File: rtl/mux_16bit_5i_1o_pkg.sv
// Shared constants for the five-input datapath word selector.
// Select codes, select width, input count and default word width.
package mux_16bit_5i_1o_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int SEL_W     = 3;
  localparam int NUM_IN    = 5;

  localparam logic [SEL_W-1:0] SEL_A = 3'd0;
  localparam logic [SEL_W-1:0] SEL_B = 3'd1;
  localparam logic [SEL_W-1:0] SEL_C = 3'd2;
  localparam logic [SEL_W-1:0] SEL_D = 3'd3;
  localparam logic [SEL_W-1:0] SEL_E = 3'd4;

endpackage

// File: rtl/mux_16bit_5i_1o_if.sv
// Bus bundle for the word selector: select, five sources, error clear and results.
// The master drives select and sources; the slave (the selector) drives the results.
interface mux_16bit_5i_1o_if
  import mux_16bit_5i_1o_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [SEL_W-1:0] s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic             err_clr;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_q;
  logic             sel_err;
  logic             err_sticky;

  modport master (
    output s, a, b, c, d, e, err_clr,
    input  r, r_q, sel_err, err_sticky
  );

  modport slave (
    input  s, a, b, c, d, e, err_clr,
    output r, r_q, sel_err, err_sticky
  );

endinterface

// File: rtl/mux_16bit_5i_1o_comb.sv
// Pure combinational 5:1 word select with out-of-range detection.
// Out-of-range or unknown selects fall into the default arm, so no latch is possible.
module mux_5to1_comb
  import mux_16bit_5i_1o_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_e,
  output logic [WIDTH-1:0] o_r,
  output logic             o_sel_err
);

  always_comb begin
    o_r = '0;
    case (i_sel)
      SEL_A:   o_r = i_a;
      SEL_B:   o_r = i_b;
      SEL_C:   o_r = i_c;
      SEL_D:   o_r = i_d;
      SEL_E:   o_r = i_e;
      default: o_r = '0;
    endcase
  end

  assign o_sel_err = (i_sel >= SEL_W'(NUM_IN));

endmodule

// File: rtl/mux_16bit_5i_1o.sv
// Top-level word selector: combinational result plus a registered copy and a
// sticky select-range error flag that software clears with err_clr.
module mux_16bit_5i_1o
  import mux_16bit_5i_1o_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_16bit_5i_1o_if.slave    bus
);

  logic [WIDTH-1:0] w_r;
  logic             w_sel_err;
  logic [WIDTH-1:0] r_rq;
  logic             r_err_sticky;

  mux_5to1_comb #(
    .WIDTH (WIDTH)
  ) u_sel (
    .i_sel     (bus.s),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .i_c       (bus.c),
    .i_d       (bus.d),
    .i_e       (bus.e),
    .o_r       (w_r),
    .o_sel_err (w_sel_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq <= '0;
    end else begin
      r_rq <= w_r;
    end
  end

  // Clear has priority so software can always drop the flag, even mid-error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (bus.err_clr) begin
      r_err_sticky <= 1'b0;
    end else if (w_sel_err) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign bus.r          = w_r;
  assign bus.sel_err    = w_sel_err;
  assign bus.r_q        = r_rq;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_mux_16bit_5i_1o.sv
// Directed bench for the word selector: stimulus pushes expectations into a
// queue and a separate monitor pops and compares them against the bus.
module tb_mux_16bit_5i_1o;

  localparam logic [3:0] M_R = 4'b0001;
  localparam logic [3:0] M_S = 4'b0010;
  localparam logic [3:0] M_Q = 4'b0100;
  localparam logic [3:0] M_K = 4'b1000;

  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic [15:0] r;
    logic        sel;
    logic [15:0] rq;
    logic        sticky;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  event ev_check;
  int   checks;
  int   errors;

  mux_16bit_5i_1o_if bus ();

  mux_16bit_5i_1o dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string name, input logic [3:0] mask,
                            input logic [15:0] r, input logic sel,
                            input logic [15:0] rq, input logic sticky);
    exp_t e;
    e.name = name; e.mask = mask; e.r = r; e.sel = sel; e.rq = rq; e.sticky = sticky;
    sb_q.push_back(e);
    -> ev_check;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_check);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.mask[0]) begin
          checks++;
          if (bus.r !== e.r) begin
            errors++;
            $display("FAIL %s r: got %h expected %h", e.name, bus.r, e.r);
          end
        end
        if (e.mask[1]) begin
          checks++;
          if (bus.sel_err !== e.sel) begin
            errors++;
            $display("FAIL %s sel_err: got %b expected %b", e.name, bus.sel_err, e.sel);
          end
        end
        if (e.mask[2]) begin
          checks++;
          if (bus.r_q !== e.rq) begin
            errors++;
            $display("FAIL %s r_q: got %h expected %h", e.name, bus.r_q, e.rq);
          end
        end
        if (e.mask[3]) begin
          checks++;
          if (bus.err_sticky !== e.sticky) begin
            errors++;
            $display("FAIL %s err_sticky: got %b expected %b", e.name, bus.err_sticky, e.sticky);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [15:0] exp_vals [5];
    exp_vals = '{16'd8, 16'd16, 16'd32, 16'd64, 16'd128};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.s = 3'd0; bus.err_clr = 1'b0;
    bus.a = 16'd8; bus.b = 16'd16; bus.c = 16'd32; bus.d = 16'd64; bus.e = 16'd128;
    #1;
    expect_out("reset", M_R | M_S | M_Q | M_K, 16'd8, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.s = 3'(i);
      #100;
      expect_out($sformatf("sel%0d", i), M_R | M_S | M_Q | M_K, exp_vals[i], 1'b0, exp_vals[i], 1'b0);
    end

    @(negedge clk);
    bus.s = 3'd5;
    #1;
    expect_out("sel5", M_R | M_S, 16'd0, 1'b1, 16'd0, 1'b0);
    @(negedge clk);
    expect_out("sel5_edge", M_Q | M_K, 16'd0, 1'b0, 16'd0, 1'b1);
    bus.s = 3'd6;
    #1;
    expect_out("sel6", M_R | M_S, 16'd0, 1'b1, 16'd0, 1'b0);
    bus.s = 3'd7;
    #1;
    expect_out("sel7", M_R | M_S | M_K, 16'd0, 1'b1, 16'd0, 1'b1);

    @(negedge clk);
    bus.s = 3'd1; bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    #1;
    expect_out("clr", M_R | M_S | M_K, 16'd16, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    bus.s = 3'd6; bus.err_clr = 1'b1;
    @(negedge clk);
    expect_out("clr_wins", M_S | M_K, 16'd0, 1'b1, 16'd0, 1'b0);
    @(negedge clk);
    expect_out("clr_hold", M_K, 16'd0, 1'b0, 16'd0, 1'b0);
    bus.err_clr = 1'b0;
    @(negedge clk);
    expect_out("reset_after_clr", M_K | M_Q, 16'd0, 1'b0, 16'd0, 1'b1);

    @(negedge clk);
    bus.s = 3'd2;
    @(negedge clk);
    expect_out("c_before", M_R | M_Q, 16'd32, 1'b0, 16'd32, 1'b0);
    bus.c = 16'hFFFF;
    #1;
    expect_out("c_change", M_R | M_Q, 16'hFFFF, 1'b0, 16'd32, 1'b0);
    @(negedge clk);
    expect_out("c_reg", M_Q, 16'd0, 1'b0, 16'hFFFF, 1'b0);

    @(negedge clk);
    bus.s = 3'd7;
    @(negedge clk);
    bus.s = 3'd4;
    @(negedge clk);
    expect_out("pre_rst", M_R | M_Q | M_K, 16'd128, 1'b0, 16'd128, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", M_R | M_S | M_Q | M_K, 16'd128, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    bus.s = 3'd0;
    #1;
    expect_out("rst_comb", M_R | M_S | M_Q, 16'd8, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    expect_out("rst_hold", M_Q | M_K, 16'd0, 1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_out("rst_release", M_Q | M_K, 16'd0, 1'b0, 16'd8, 1'b0);

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
